// File: rtl/bsg_round_robin_fifo_pair.sv
// bsg_round_robin_fifo_pair
//
// Two-wide in-order buffer made of two single-lane FIFO banks. Elements are
// written into the banks alternately, starting at bank head_r, and are read
// back alternately, starting at bank tail_r. Because the banks are always
// filled and drained in strict alternation, the oldest element sits in bank
// tail_r and the next oldest sits in bank ~tail_r.
//
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous, active-high reset; empties the buffer
//   data_i   : two input lanes, lane 0 = [width_p-1:0] (older), lane 1 above it
//   v_i      : input lane valids (00, 01 or 11)
//   ready_o  : per-lane ready (00, 01 or 11)
//   data_o   : lane 0 = oldest buffered element, lane 1 = next oldest
//   v_o      : output lane valids (00, 01 or 11)
//   yumi_i   : per-lane dequeue (00, 01 or 11, subset of v_o)
//
// Handshake: an input lane is accepted on a rising clock edge when both its
// v_i bit and its ready_o bit are 1; an output lane is consumed on a rising
// edge when its yumi_i bit is 1, which the consumer may only assert while the
// matching v_o bit is 1. ready_o, v_o and data_o are derived from registered
// state (and reset_i) only, so they never depend on v_i or yumi_i.

module bsg_round_robin_fifo_pair #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [2*width_p-1:0]   data_i,
    input  logic [1:0]             v_i,
    output logic [1:0]             ready_o,
    output logic [2*width_p-1:0]   data_o,
    output logic [1:0]             v_o,
    input  logic [1:0]             yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

    logic                head_r;
    logic                tail_r;
    logic [ptr_w_lp-1:0] wp_r    [2];
    logic [ptr_w_lp-1:0] rp_r    [2];
    logic [cnt_w_lp-1:0] count_r [2];
    logic [width_p-1:0]  mem_r   [2][els_p];

    logic [1:0]          enq;
    logic [1:0]          deq;
    logic [1:0]          wr_en;
    logic [1:0]          rd_en;
    logic [width_p-1:0]  wr_data [2];
    logic [cnt_w_lp-1:0] cnt_head;
    logic [cnt_w_lp-1:0] cnt_head_n;
    logic [cnt_w_lp-1:0] cnt_tail;
    logic [cnt_w_lp-1:0] cnt_tail_n;

    assign cnt_head   = count_r[head_r];
    assign cnt_head_n = count_r[~head_r];
    assign cnt_tail   = count_r[tail_r];
    assign cnt_tail_n = count_r[~tail_r];

    // Lane 1 is only ever ready/valid together with lane 0, which keeps both
    // sides in the legal 00/01/11 patterns.
    always_comb begin
        ready_o    = 2'b00;
        v_o        = 2'b00;
        if (!reset_i) begin
            ready_o[0] = (cnt_head != full_cnt_lp);
            ready_o[1] = ready_o[0] & (cnt_head_n != full_cnt_lp);
            v_o[0]     = (cnt_tail != '0);
            v_o[1]     = v_o[0] & (cnt_tail_n != '0);
        end
    end

    assign data_o = {mem_r[~tail_r][rp_r[~tail_r]], mem_r[tail_r][rp_r[tail_r]]};

    assign enq = v_i & ready_o;
    // Gating with v_o keeps a misbehaving consumer from underflowing a bank.
    assign deq = yumi_i & v_o;

    // Steer lanes to banks: lane 0 to head_r / tail_r, lane 1 to the other.
    always_comb begin
        wr_en   = 2'b00;
        rd_en   = 2'b00;
        wr_data[0] = data_i[width_p-1:0];
        wr_data[1] = data_i[width_p-1:0];
        for (int b = 0; b < 2; b++) begin
            if (b[0] == head_r) begin
                wr_en[b]   = enq[0];
                wr_data[b] = data_i[width_p-1:0];
            end else begin
                wr_en[b]   = enq[1];
                wr_data[b] = data_i[2*width_p-1:width_p];
            end
            rd_en[b] = (b[0] == tail_r) ? deq[0] : deq[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r <= 1'b0;
            tail_r <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                wp_r[b]    <= '0;
                rp_r[b]    <= '0;
                count_r[b] <= '0;
            end
        end else begin
            // An odd number of moves flips the bank that comes next.
            head_r <= head_r ^ enq[0] ^ enq[1];
            tail_r <= tail_r ^ deq[0] ^ deq[1];
            for (int b = 0; b < 2; b++) begin
                if (wr_en[b]) begin
                    wp_r[b] <= (wp_r[b] == last_ptr_lp) ? '0 : wp_r[b] + ptr_w_lp'(1);
                end
                if (rd_en[b]) begin
                    rp_r[b] <= (rp_r[b] == last_ptr_lp) ? '0 : rp_r[b] + ptr_w_lp'(1);
                end
                count_r[b] <= count_r[b] + cnt_w_lp'(wr_en[b]) - cnt_w_lp'(rd_en[b]);
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 2; b++) begin
            if (wr_en[b] && !reset_i) begin
                mem_r[b][wp_r[b]] <= wr_data[b];
            end
        end
    end

`ifndef SYNTHESIS
    a_legal_v_i : assert property (@(posedge clk_i) disable iff (reset_i)
        v_i != 2'b10)
        else $error("bsg_round_robin_fifo_pair: illegal v_i pattern 10");

    a_legal_yumi_i : assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_i != 2'b10)
        else $error("bsg_round_robin_fifo_pair: illegal yumi_i pattern 10");

    a_yumi_subset : assert property (@(posedge clk_i) disable iff (reset_i)
        (yumi_i & ~v_o) == 2'b00)
        else $error("bsg_round_robin_fifo_pair: yumi_i asserted without v_o");

    // The tail bank never holds fewer elements than the other bank and at
    // most one more; head_r sits one bank past tail_r when the total is odd.
    a_balanced : assert property (@(posedge clk_i) disable iff (reset_i)
        (cnt_tail == cnt_tail_n) || ({1'b0, cnt_tail} == {1'b0, cnt_tail_n} + 1'b1))
        else $error("bsg_round_robin_fifo_pair: bank counts out of balance");

    a_parity : assert property (@(posedge clk_i) disable iff (reset_i)
        head_r == (tail_r ^ count_r[0][0] ^ count_r[1][0]))
        else $error("bsg_round_robin_fifo_pair: head/tail parity broken");
`endif

endmodule
